vec_pe_sequencer: RTL and testbench
===================================

// Module: vec_pe_sequencer
// PURPOSE
//  Sequences one vector instruction across the NUM_PE shared vector processing elements (PEs).
//  - On start, latches the operand registers, funct6, vsew and vl.
//  - Each cycle, issues up to NUM_PE elements to the PEs and captures their combinational results.
//  - Packs the captured results into a VREG_W-bit destination value and pulses done.
//  Sits between vector decode/regfile read and vector writeback.
// PARAMETERS
//  NUM_PE   4    PE lanes issued per cycle; must be a power of two, 1..8
//  VREG_W   256  vector register width in bits
//  PE_W     32   PE operand/result width; widest supported SEW
// PORTS
//  clk          in   1              clock, rising edge
//  reset        in   1              asynchronous, active-high
//  start        in   1              request; accepted only when busy==0
//  vsew         in   3              000=8b, 001=16b, 010=32b; others illegal
//  funct6       in   6              operation code, passed through to PEs
//  vl           in   32             active element count
//  operand_a    in   VREG_W         vs2 register value
//  operand_b    in   VREG_W         vs1 register value
//  pe_a         out  NUM_PE*PE_W    lane k occupies bits [k*PE_W +: PE_W], zero-extended element
//  pe_b         out  NUM_PE*PE_W    same layout as pe_a
//  pe_en        out  NUM_PE         lane k carries an active element
//  pe_funct6    out  6              latched funct6
//  pe_result    in   NUM_PE*PE_W    combinational PE results, same layout as pe_a
//  busy         out  1              instruction in flight
//  done         out  1              one-cycle pulse: vec_out is valid
//  err          out  1              qualified by done; illegal vsew
//  vec_out      out  VREG_W         packed result; held until the next accepted start
// BEHAVIOUR
//  Reset values: every output is 0; state=IDLE; count=0.
//  Start acceptance: start&&!busy moves IDLE->RUN. At the same edge the block
//   - latches operands, funct6 and vsew,
//   - computes vl_eff = min(vl, VREG_W>>(3+vsew)),
//   - clears vec_out and sets count=0.
//  start while busy: ignored; latched values are not disturbed.
//  Illegal vsew on start: IDLE->DONE directly. done=1, err=1, vec_out=0. PEs are never enabled.
//  vl_eff==0 on start: IDLE->DONE directly. done=1, err=0, vec_out=0.
//  RUN state, each cycle:
//   - Lane k carries element e=count+k.
//   - pe_en[k] = (e < vl_eff).
//   - pe_a/pe_b lane k = element e of operand_a/operand_b, zero-extended to PE_W.
//   - Disabled lanes drive 0.
//   - At the clock edge, for each enabled lane, vec_out[e*SEW +: SEW] <= pe_result lane k [SEW-1:0]. Upper result bits are discarded.
//   - Then count += NUM_PE.
//  RUN->DONE when count+NUM_PE >= vl_eff.
//  DONE state: done=1 for exactly one cycle, then DONE->IDLE.
//  busy=1 in RUN and DONE, 0 in IDLE. A new start is therefore accepted in the cycle after done.
//  Latency: start accepted at edge T. RUN occupies N=ceil(vl_eff/NUM_PE) cycles. done is high in cycle T+N+1 (T+1 for the error and vl==0 paths).
//  Tail elements (index >= vl_eff) read back 0 in vec_out.
//  pe_funct6 holds the latched funct6 from acceptance until the next accepted start.
//  Reset mid-operation: immediate return to IDLE with all outputs 0. No done is emitted.
// TESTING
//  1. vsew=000, vl=32, funct6=add PE, a bytes=i, b bytes=1 -> 8 RUN cycles; done 9 cycles after start; vec_out byte i = i+1.
//  2. vsew=010, vl=5, NUM_PE=4 -> RUN 2 cycles; pe_en=1111 then 0001; vec_out words 5..7 = 0.
//  3. vsew=010, vl=100 -> clamped to 8; 2 RUN cycles; all 8 words written.
//  4. vl=0, then vsew=011 -> each gives done 1 cycle after start with vec_out=0; err=0 then err=1; pe_en never set.
//  5. Second start pulsed during RUN of vsew=001 vl=16 -> ignored; result and latency match a lone op; back-to-back start accepted the cycle after done.
//  6. Assert reset in the 2nd RUN cycle -> busy/done/vec_out/pe_en go 0 immediately; a following start runs correctly.

Source files
------------

// File: rtl/vec_pe_sequencer.sv
// Issues one vector instruction across NUM_PE combinational PEs, NUM_PE elements per cycle,
// and packs the SEW-truncated lane results into a VREG_W-bit destination value.
module vec_pe_sequencer #(
  parameter int NUM_PE = 4,
  parameter int VREG_W = 256,
  parameter int PE_W   = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [2:0]             i_vsew,
  input  logic [5:0]             i_funct6,
  input  logic [31:0]            i_vl,
  input  logic [VREG_W-1:0]      i_operand_a,
  input  logic [VREG_W-1:0]      i_operand_b,
  output logic [NUM_PE*PE_W-1:0] o_pe_a,
  output logic [NUM_PE*PE_W-1:0] o_pe_b,
  output logic [NUM_PE-1:0]      o_pe_en,
  output logic [5:0]             o_pe_funct6,
  input  logic [NUM_PE*PE_W-1:0] i_pe_result,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [VREG_W-1:0]      o_vec_out,
  output logic [1:0]             o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [VREG_W-1:0]   r_a;
  logic [VREG_W-1:0]   r_b;
  logic [5:0]          r_funct6;
  logic [1:0]          r_vsew;
  logic [31:0]         r_vl_eff;
  logic [31:0]         r_count;
  logic                r_err;
  logic [VREG_W-1:0]   r_vec_out;

  logic                w_accept;
  logic                w_vsew_bad;
  logic [31:0]         w_max_el;
  logic [31:0]         w_vl_eff;
  logic [31:0]         w_sew;
  logic [PE_W-1:0]     w_sew_mask;
  logic [31:0]         w_bitoff [NUM_PE];
  logic                w_lane_on [NUM_PE];
  logic [VREG_W-1:0]   w_vec_next;

  assign w_accept   = i_start && (r_state == S_IDLE);
  assign w_vsew_bad = (i_vsew > 3'd2);
  assign w_max_el   = 32'(VREG_W >> (32'd3 + 32'(i_vsew)));
  assign w_vl_eff   = (i_vl < w_max_el) ? i_vl : w_max_el;
  assign w_sew      = 32'd8 << r_vsew;

  always_comb begin
    w_sew_mask = '1;
    case (r_vsew)
      2'd0:    w_sew_mask = PE_W'(8'hFF);
      2'd1:    w_sew_mask = PE_W'(16'hFFFF);
      default: w_sew_mask = '1;
    endcase
  end

  // Lane k works on element count+k; bit offsets are in the destination register.
  always_comb begin
    for (int k = 0; k < NUM_PE; k++) begin
      w_lane_on[k] = (r_state == S_RUN) && ((r_count + 32'(k)) < r_vl_eff);
      w_bitoff[k]  = (r_count + 32'(k)) * w_sew;
    end
  end

  always_comb begin
    o_pe_a     = '0;
    o_pe_b     = '0;
    o_pe_en    = '0;
    w_vec_next = r_vec_out;
    for (int k = 0; k < NUM_PE; k++) begin
      if (w_lane_on[k]) begin
        o_pe_en[k]               = 1'b1;
        o_pe_a[k*PE_W +: PE_W]   = PE_W'(r_a >> w_bitoff[k]) & w_sew_mask;
        o_pe_b[k*PE_W +: PE_W]   = PE_W'(r_b >> w_bitoff[k]) & w_sew_mask;
        w_vec_next = (w_vec_next & ~(VREG_W'(w_sew_mask) << w_bitoff[k]))
                   | (VREG_W'(i_pe_result[k*PE_W +: PE_W] & w_sew_mask) << w_bitoff[k]);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_vsew_bad || (w_vl_eff == 32'd0)) w_state_next = S_DONE;
          else                                   w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if ((r_count + 32'(NUM_PE)) >= r_vl_eff) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_funct6  <= '0;
      r_vsew    <= '0;
      r_vl_eff  <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_vec_out <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a       <= i_operand_a;
        r_b       <= i_operand_b;
        r_funct6  <= i_funct6;
        r_vsew    <= i_vsew[1:0];
        r_vl_eff  <= w_vl_eff;
        r_count   <= '0;
        r_err     <= w_vsew_bad;
        r_vec_out <= '0;
      end else if (r_state == S_RUN) begin
        r_vec_out <= w_vec_next;
        r_count   <= r_count + 32'(NUM_PE);
      end
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_err       = o_done && r_err;
  assign o_vec_out   = r_vec_out;
  assign o_pe_funct6 = r_funct6;
  assign o_state     = r_state;

endmodule

// File: tb/tb_vec_pe_sequencer.sv
// Bench for vec_pe_sequencer: directed scenarios plus random instructions, with a PE model
// driving pe_result and an element-level reference model producing expected results.
module tb_vec_pe_sequencer;
  localparam int NUM_PE = 4;
  localparam int VREG_W = 256;
  localparam int PE_W   = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [2:0]             vsew;
  logic [5:0]             funct6;
  logic [31:0]            vl;
  logic [VREG_W-1:0]      operand_a;
  logic [VREG_W-1:0]      operand_b;
  logic [NUM_PE*PE_W-1:0] pe_a;
  logic [NUM_PE*PE_W-1:0] pe_b;
  logic [NUM_PE-1:0]      pe_en;
  logic [5:0]             pe_funct6;
  logic [NUM_PE*PE_W-1:0] pe_result;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [VREG_W-1:0]      vec_out;
  logic [1:0]             state;

  int vectors = 0;
  int miscompares = 0;
  logic [VREG_W-1:0] exp_q[$];

  vec_pe_sequencer #(.NUM_PE(NUM_PE), .VREG_W(VREG_W), .PE_W(PE_W)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_vsew(vsew), .i_funct6(funct6),
    .i_vl(vl), .i_operand_a(operand_a), .i_operand_b(operand_b),
    .o_pe_a(pe_a), .o_pe_b(pe_b), .o_pe_en(pe_en), .o_pe_funct6(pe_funct6),
    .i_pe_result(pe_result), .o_busy(busy), .o_done(done), .o_err(err),
    .o_vec_out(vec_out), .o_state(state)
  );

  always #5 clk = ~clk;

  // PE behaviour: full 32-bit arithmetic, so results can carry bits above SEW.
  function automatic logic [31:0] pe_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    case (f[1:0])
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return x ^ y;
      default: return x * y;
    endcase
  endfunction

  always_comb begin
    pe_result = '0;
    for (int k = 0; k < NUM_PE; k++)
      pe_result[k*PE_W +: PE_W] = pe_op(pe_funct6, pe_a[k*PE_W +: PE_W], pe_b[k*PE_W +: PE_W]);
  end

  function automatic int ref_vl_eff(input logic [2:0] s, input logic [31:0] l);
    int mx;
    if (s > 3'd2) return 0;
    mx = VREG_W >> (3 + int'(s));
    return (l < 32'(mx)) ? int'(l) : mx;
  endfunction

  function automatic logic [VREG_W-1:0] ref_vec(input logic [2:0] s, input logic [31:0] l,
      input logic [5:0] f, input logic [VREG_W-1:0] a, input logic [VREG_W-1:0] b);
    logic [VREG_W-1:0] r;
    logic [31:0] x, y, z, m;
    int sew, n;
    r = '0;
    if (s > 3'd2) return r;
    sew = 8 << s;
    n = ref_vl_eff(s, l);
    m = (sew == 32) ? 32'hFFFF_FFFF : ((32'd1 << sew) - 32'd1);
    for (int e = 0; e < n; e++) begin
      x = 32'(a >> (e * sew)) & m;
      y = 32'(b >> (e * sew)) & m;
      z = pe_op(f, x, y) & m;
      r = r | (VREG_W'(z) << (e * sew));
    end
    return r;
  endfunction

  function automatic logic [NUM_PE-1:0] ref_en(input int cyc, input int n);
    logic [NUM_PE-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_PE; k++) if (cyc * NUM_PE + k < n) r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [VREG_W-1:0] rand_vec();
    logic [VREG_W-1:0] r;
    for (int i = 0; i < VREG_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string tag, input logic [VREG_W-1:0] obs, input logic [VREG_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Holds start until accepted, then follows the instruction to done.
  // Returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [2:0] s, input logic [31:0] l,
      input logic [5:0] f, input logic [VREG_W-1:0] a, input logic [VREG_W-1:0] b,
      input bit poke, input int exp_wait, output logic [VREG_W-1:0] expv);
    int n_eff, n_run, waits, cyc;
    bit bad;
    bad   = (s > 3'd2);
    n_eff = ref_vl_eff(s, l);
    n_run = bad ? 0 : (n_eff + NUM_PE - 1) / NUM_PE;
    expv  = ref_vec(s, l, f, a, b);
    exp_q.push_back(expv);
    vsew = s; vl = l; funct6 = f; operand_a = a; operand_b = b; start = 1'b1;
    waits = 0;
    while (busy && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    check($sformatf("%s_accept_wait", tag), VREG_W'(waits), VREG_W'(exp_wait));
    @(negedge clk);
    start = 1'b0;
    operand_a = rand_vec(); operand_b = rand_vec(); funct6 = 6'(~f); vsew = 3'd0; vl = 32'd32;
    cyc = 1;
    while (!done && cyc <= 100) begin
      start = 1'b0;
      check($sformatf("%s_pe_en_c%0d", tag, cyc), VREG_W'(pe_en), VREG_W'(ref_en(cyc - 1, n_eff)));
      check($sformatf("%s_busy_c%0d", tag, cyc), VREG_W'(busy), VREG_W'(1));
      if (poke && cyc == 2) begin
        start = 1'b1; operand_a = rand_vec(); operand_b = rand_vec();
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check($sformatf("%s_latency", tag), VREG_W'(cyc), VREG_W'(n_run + 1));
    check($sformatf("%s_err", tag), VREG_W'(err), VREG_W'(bad));
    check($sformatf("%s_vec_out", tag), vec_out, exp_q.pop_front());
    check($sformatf("%s_done_pe_en", tag), VREG_W'(pe_en), VREG_W'(0));
    check($sformatf("%s_funct6", tag), VREG_W'(pe_funct6), VREG_W'(f));
  endtask

  initial begin
    logic [VREG_W-1:0] a, b, ev;
    reset = 1'b1; start = 1'b0; vsew = '0; funct6 = '0; vl = '0; operand_a = '0; operand_b = '0;
    // clock/reset
    repeat (2) @(negedge clk);
    check("rst_busy", VREG_W'(busy), VREG_W'(0));
    check("rst_done", VREG_W'(done), VREG_W'(0));
    check("rst_vec_out", vec_out, '0);
    check("rst_pe_en", VREG_W'(pe_en), VREG_W'(0));
    check("rst_pe_a", VREG_W'(pe_a), VREG_W'(0));
    reset = 1'b0;
    @(negedge clk);

    // bytes: a=i, b=1, add
    for (int i = 0; i < 32; i++) begin
      a[i*8 +: 8] = 8'(i);
      b[i*8 +: 8] = 8'd1;
    end
    run_op("t1_add8", 3'd0, 32'd32, 6'd0, a, b, 1'b0, 0, ev);
    for (int i = 0; i < 32; i++)
      check($sformatf("t1_byte%0d", i), VREG_W'(ev[i*8 +: 8]), VREG_W'(i + 1));
    @(negedge clk);
    check("t1_hold", vec_out, ev);
    check("t1_idle", VREG_W'(busy), VREG_W'(0));

    run_op("t2_vl5", 3'd2, 32'd5, 6'd1, rand_vec(), rand_vec(), 1'b0, 0, ev);
    check("t2_tail", VREG_W'(vec_out[VREG_W-1:160]), VREG_W'(0));
    run_op("t3_clamp", 3'd2, 32'd100, 6'd2, rand_vec(), rand_vec(), 1'b0, 1, ev);
    run_op("t4_vl0", 3'd0, 32'd0, 6'd0, rand_vec(), rand_vec(), 1'b0, 1, ev);
    run_op("t4_badsew", 3'd3, 32'd8, 6'd0, rand_vec(), rand_vec(), 1'b0, 1, ev);
    run_op("t5_poke", 3'd1, 32'd16, 6'd3, rand_vec(), rand_vec(), 1'b1, 1, ev);
    run_op("t5_b2b", 3'd0, 32'($urandom_range(1, 40)), 6'd1, rand_vec(), rand_vec(), 1'b0, 1, ev);

    // reset in the 2nd RUN cycle
    @(negedge clk);
    vsew = 3'd0; vl = 32'd32; funct6 = 6'd2; operand_a = rand_vec(); operand_b = rand_vec(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t6_run_pe_en", VREG_W'(pe_en), VREG_W'(4'hF));
    reset = 1'b1;
    #1;
    check("t6_busy", VREG_W'(busy), VREG_W'(0));
    check("t6_done", VREG_W'(done), VREG_W'(0));
    check("t6_vec_out", vec_out, '0);
    check("t6_pe_en", VREG_W'(pe_en), VREG_W'(0));
    check("t6_funct6", VREG_W'(pe_funct6), VREG_W'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op("t6_after", 3'd0, 32'd32, 6'd0, rand_vec(), rand_vec(), 1'b0, 0, ev);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 3)), 32'($urandom_range(0, 40)),
             6'($urandom_range(0, 63)), rand_vec(), rand_vec(), 1'($urandom_range(0, 1)), 1, ev);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
